// File: rtl/uarc_receiver_arbiter.sv
// Shares one core receive path among all UARC buses: arbitrates kill/send requests, holds the winner
// in a valid/ready message register and returns a one-cycle ack. Build option: UARC_RECV_ARB_FIXED_PRIO_EN.
module uarc_receiver_arbiter #(
    parameter int WORD_MAG  = 5,
    parameter int UARC_SETS = 1,
    localparam int WORD_WIDTH  = 1 << WORD_MAG,
    localparam int TOTAL_BUSES = UARC_SETS * WORD_WIDTH,
    localparam int IDX_WIDTH   = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [TOTAL_BUSES-1:0]            receiver_enable,
    input  logic [TOTAL_BUSES-1:0]            receiver_kills,
    output logic [TOTAL_BUSES-1:0]            receiver_kill_acks,
    input  logic [TOTAL_BUSES-1:0]            receiver_sends,
    output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
    input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
    input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_self_permissions,
    input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_self_addresses,
    output logic                              msg_valid,
    input  logic                              msg_ready,
    output logic                              msg_kill,
    output logic [IDX_WIDTH-1:0]              msg_bus,
    output logic [WORD_WIDTH-1:0]             msg_data,
    output logic [WORD_WIDTH-1:0]             msg_permission,
    output logic [WORD_WIDTH-1:0]             msg_address
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [TOTAL_BUSES-1:0] kreq, sreq, req_vec, bus_onehot;
    logic [IDX_WIDTH-1:0]   scan_base, pick_idx;
    logic [IDX_WIDTH:0]     scan;
    logic                   pick_kill, pick_found, accept;

`ifdef UARC_RECV_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [IDX_WIDTH-1:0] rr_ptr;
    assign scan_base = rr_ptr;
`endif

    assign msg_valid  = (state == VALID);
    assign accept     = (state == VALID) && msg_ready;
    assign bus_onehot = TOTAL_BUSES'(1) << msg_bus;

    // Kills form a strictly higher class; the scan starts at scan_base and wraps.
    always_comb begin
        kreq       = receiver_enable & receiver_kills;
        sreq       = receiver_enable & receiver_sends & ~receiver_kills;
        pick_kill  = |kreq;
        req_vec    = pick_kill ? kreq : sreq;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < TOTAL_BUSES; i++) begin
            scan = {1'b0, scan_base} + (IDX_WIDTH+1)'(i);
            if (scan >= (IDX_WIDTH+1)'(TOTAL_BUSES))
                scan = scan - (IDX_WIDTH+1)'(TOTAL_BUSES);
            if (!pick_found && req_vec[scan[IDX_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = VALID;
            VALID:   if (msg_ready)  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            msg_kill           <= 1'b0;
            msg_bus            <= '0;
            msg_data           <= '0;
            msg_permission     <= '0;
            msg_address        <= '0;
            receiver_kill_acks <= '0;
            receiver_send_acks <= '0;
        end else begin
            state              <= state_nxt;
            receiver_kill_acks <= '0;
            receiver_send_acks <= '0;
            if (state == IDLE && pick_found) begin
                msg_kill       <= pick_kill;
                msg_bus        <= pick_idx;
                msg_data       <= receiver_datas[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
                msg_permission <= receiver_self_permissions[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
                msg_address    <= receiver_self_addresses[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
            end
            // The committed message is acked regardless of the requester's current level.
            if (accept) begin
                if (msg_kill) receiver_kill_acks <= bus_onehot;
                else          receiver_send_acks <= bus_onehot;
            end
        end
    end

`ifndef UARC_RECV_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (msg_bus == IDX_WIDTH'(TOTAL_BUSES-1)) ? '0 : msg_bus + 1'b1;
    end
`endif

endmodule

// File: doc/uarc_receiver_arbiter.md
Name: uarc_receiver_arbiter

Overview:
- Shares the core0 receive path among all TOTAL_BUSES incoming UARC buses.
- Arbitrates pending kill and send requests and latches the winner's data, self permission and self address into a single message register.
- Presents that message to the core through a valid/ready handshake.
- Returns the one-cycle kill or send ack to the winning bus once the core accepts.

Parameters:
- WORD_MAG, 5: log2 of the word width; WORD_WIDTH = 1 << WORD_MAG.
- UARC_SETS, 1: number of bus sets; TOTAL_BUSES = UARC_SETS * WORD_WIDTH.
- IDX_WIDTH (localparam): $clog2(TOTAL_BUSES), minimum 1.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- receiver_enable  in  TOTAL_BUSES  per-bus enable; requests are qualified by it.
- receiver_kills  in  TOTAL_BUSES  per-bus kill request level.
- receiver_kill_acks  out  TOTAL_BUSES  one-cycle kill ack to the granted bus.
- receiver_sends  in  TOTAL_BUSES  per-bus send request level.
- receiver_send_acks  out  TOTAL_BUSES  one-cycle send ack to the granted bus.
- receiver_datas  in  TOTAL_BUSES x WORD_WIDTH  per-bus data.
- receiver_self_permissions  in  TOTAL_BUSES x WORD_WIDTH  per-bus permission.
- receiver_self_addresses  in  TOTAL_BUSES x WORD_WIDTH  per-bus address.
- msg_valid  out  1  message register holds an unaccepted message.
- msg_ready  in  1  core accepts the message this cycle.
- msg_kill  out  1  1 = kill message, 0 = send message.
- msg_bus  out  IDX_WIDTH  index of the granted bus.
- msg_data  out  WORD_WIDTH  latched data.
- msg_permission  out  WORD_WIDTH  latched self permission.
- msg_address  out  WORD_WIDTH  latched self address.

Behaviour:
- Request vectors:
  - kreq = receiver_enable & receiver_kills.
  - sreq = receiver_enable & receiver_sends & ~receiver_kills. A bus raising both is treated as kill only.
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; rr_ptr = 0.
  - msg_valid, msg_kill, all ack bits = 0; msg_bus/data/permission/address = 0.
- State IDLE:
  - If kreq != 0, pick a winner from kreq; otherwise, if sreq != 0, pick a winner from sreq. Kills strictly beat sends.
  - Winner is the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo TOTAL_BUSES.
  - On a win: latch index, kind and the winner's data/permission/address; set msg_valid = 1 in the next cycle; go to VALID.
  - No request: stay in IDLE, msg_valid = 0.
- State VALID:
  - msg_* fields are held stable.
  - On msg_ready = 1: msg_valid drops next cycle; next cycle raises receiver_kill_acks[msg_bus] if msg_kill, else receiver_send_acks[msg_bus]; rr_ptr = msg_bus + 1 (wraps to 0 past TOTAL_BUSES-1); go to ACK.
  - Without msg_ready: stay in VALID indefinitely.
- State ACK:
  - The ack bit is high for exactly this one cycle; the requester deasserts its request in response.
  - Go to IDLE. No arbitration happens in ACK, so a still-high request from the just-acked bus is not re-granted.
- Latency and throughput:
  - Request sampled in IDLE at edge N gives msg_valid = 1 after edge N.
  - msg_ready sampled at edge M gives an ack pulse in cycle M..M+1.
  - Next arbitration happens at edge M+2. Peak rate is one message per 3 cycles.
- Commitment: once latched, a message is committed. Dropping its request or enable while in VALID does not cancel it; the ack is still issued.
- Ack outputs are registered, never combinational from inputs. At most one ack bit across both vectors is high in any cycle.
- msg_ready while msg_valid = 0 is ignored.

Optional Feature:
- Macro: UARC_RECV_ARB_FIXED_PRIO_EN.
- Defined: round-robin is disabled; the lowest set index always wins within the kill class and within the send class; rr_ptr is not implemented.
- Undefined: round-robin as described in Behaviour.
- Kill-over-send priority applies in both builds.

Test Plan:
- Reset: assert reset = 0 mid-VALID with msg_ready = 0 → msg_valid = 0, all acks 0, and the next grant after release scans from bus 0.
- Single send: bus 3 raises enable and send with data 0xDEADBEEF, permission 0x11, address 0x22; msg_ready = 1 once msg_valid = 1 → msg_bus = 3, msg_kill = 0, fields match, receiver_send_acks = 1<<3 for exactly one cycle.
- Round-robin: buses 0, 5 and 31 hold send and drop it one cycle after their ack; msg_ready is tied high → grant order 0, 5, 31, 0; one ack every 3 cycles.
- Kill priority: bus 2 raises send and bus 9 raises kill in the same cycle → bus 9 is granted first with msg_kill = 1 and receiver_kill_acks[9] pulses; bus 2 is granted next.
- Backpressure and commit: bus 7 is granted; msg_ready is held 0 for 10 cycles while bus 7 drops enable → msg fields remain stable and receiver_send_acks[7] pulses once msg_ready = 1.
- Fixed-priority build (UARC_RECV_ARB_FIXED_PRIO_EN defined): buses 1 and 4 hold send continuously → bus 1 is always granted and bus 4 is never granted.
